// File: rtl/phase_gen_pkg.sv
// Shared definitions for the multi-phase non-overlapping phase generator.
// Holds the FSM encoding, the O_S reset level and the legal parameter ranges.
package phase_gen_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACT  = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   typedef enum logic [1:0] {
      StIdle = ST_IDLE,
      StAct  = ST_ACT,
      StDead = ST_DEAD
   } state_e;

   localparam logic OS_RST = 1'b1;

   localparam int unsigned PHASES_MIN = 2;
   localparam int unsigned PHASES_MAX = 8;
   localparam int unsigned CW_MIN     = 1;
   localparam int unsigned CW_MAX     = 16;

   function automatic bit params_ok(input int unsigned phases, input int unsigned cw);
      return (phases >= PHASES_MIN) && (phases <= PHASES_MAX) &&
             (cw >= CW_MIN) && (cw <= CW_MAX);
   endfunction

endpackage

// File: rtl/phase_gen_if.sv
// Control and phase-output bundle of phase_gen; master drives control, slave is the generator.
interface phase_gen_if #(
   parameter int unsigned PHASES = 2,
   parameter int unsigned CW     = 4
) ();

   logic              i_en;
   logic              i_mode;
   logic              i_step;
   logic [CW-1:0]     i_pw;
   logic [CW-1:0]     i_gap;
   logic [PHASES-1:0] o_ph;
   logic              o_s;
   logic              o_sync;
   logic              o_busy;

   modport master (
      output i_en,
      output i_mode,
      output i_step,
      output i_pw,
      output i_gap,
      input  o_ph,
      input  o_s,
      input  o_sync,
      input  o_busy
   );

   modport slave (
      input  i_en,
      input  i_mode,
      input  i_step,
      input  i_pw,
      input  i_gap,
      output o_ph,
      output o_s,
      output o_sync,
      output o_busy
   );

endinterface

// File: rtl/phase_gen_timer.sv
// Loadable down-counter shared by the ACT (high width) and DEAD (gap) segments.
module phase_gen_timer
   import phase_gen_pkg::*;
#(
   parameter int unsigned CW = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [CW-1:0] i_load_val,
   input  logic          i_dec,
   output logic          o_zero
);

   logic [CW-1:0] r_cnt;

   // Load wins over decrement so a new segment always starts from its full count.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_dec) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/phase_gen.sv
// Multi-phase non-overlapping phase generator: FSM, phase index and registered outputs.
// All outputs are flops loaded from the next-state decode, so they never glitch.
module phase_gen
   import phase_gen_pkg::*;
#(
   parameter int unsigned PHASES = 2,
   parameter int unsigned CW     = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   phase_gen_if.slave io_bus
);

   localparam int unsigned   IW       = $clog2(PHASES);
   localparam logic [IW-1:0] IDX_LAST = IW'(PHASES - 1);

   if (!params_ok(PHASES, CW)) begin : g_param_check
      $error("phase_gen: PHASES must be 2..8 and CW 1..16");
   end

   logic              r_en;
   logic              r_mode;
   logic              r_step;
   state_e            r_state;
   state_e            w_state_d;
   logic [IW-1:0]     r_idx;
   logic [IW-1:0]     w_idx_d;
   logic [PHASES-1:0] r_ph;
   logic [PHASES-1:0] w_ph_d;
   logic              r_os;
   logic              r_sync;
   logic              r_busy;
   logic              w_go;
   logic              w_start;
   logic              w_boundary;
   logic              w_load;
   logic              w_dec;
   logic              w_zero;
   logic [CW-1:0]     w_load_val;

   // Requests are registered once: a request seen at edge k shows on the outputs after k+1.
   // STEP is dropped while busy so it can never be queued for the next frame.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_en   <= 1'b0;
         r_mode <= 1'b0;
         r_step <= 1'b0;
      end else begin
         r_en   <= io_bus.i_en;
         r_mode <= io_bus.i_mode;
         r_step <= io_bus.i_step & ~r_busy;
      end
   end

   phase_gen_timer #(
      .CW(CW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_zero     (w_zero)
   );

   always_comb begin
      w_state_d  = r_state;
      w_idx_d    = r_idx;
      w_start    = 1'b0;
      w_boundary = 1'b0;
      w_load     = 1'b0;
      w_load_val = io_bus.i_pw;
      w_dec      = 1'b0;
      w_go       = r_en & (~r_mode | r_step);

      unique case (r_state)
         StIdle: begin
            if (w_go) begin
               w_state_d = StAct;
               w_idx_d   = '0;
               w_start   = 1'b1;
            end
         end
         StAct: begin
            if (!w_zero) begin
               w_dec = 1'b1;
            end else if (io_bus.i_gap != '0) begin
               w_state_d  = StDead;
               w_load     = 1'b1;
               w_load_val = io_bus.i_gap - 1'b1;
            end else begin
               w_boundary = 1'b1;
            end
         end
         StDead: begin
            if (!w_zero) begin
               w_dec = 1'b1;
            end else begin
               w_boundary = 1'b1;
            end
         end
         default: begin
            w_state_d = StIdle;
            w_idx_d   = '0;
         end
      endcase

      // EN and MODE only matter here, so a frame in flight always completes.
      if (w_boundary) begin
         if (r_idx != IDX_LAST) begin
            w_state_d = StAct;
            w_idx_d   = r_idx + 1'b1;
            w_start   = 1'b1;
         end else if (!r_mode && r_en) begin
            w_state_d = StAct;
            w_idx_d   = '0;
            w_start   = 1'b1;
         end else begin
            w_state_d = StIdle;
            w_idx_d   = '0;
         end
      end

      if (w_start) begin
         w_load     = 1'b1;
         w_load_val = io_bus.i_pw;
      end
   end

   always_comb begin
      w_ph_d = '0;
      for (int i = 0; i < int'(PHASES); i++) begin
         w_ph_d[i] = (w_state_d == StAct) && (w_idx_d == IW'(i));
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state <= StIdle;
         r_idx   <= '0;
         r_ph    <= '0;
         r_os    <= OS_RST;
         r_sync  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_idx   <= w_idx_d;
         r_ph    <= w_ph_d;
         r_os    <= r_os ^ w_start;
         r_sync  <= w_start && (w_idx_d == '0);
         r_busy  <= (w_state_d != StIdle);
      end
   end

   assign io_bus.o_ph   = r_ph;
   assign io_bus.o_s    = r_os;
   assign io_bus.o_sync = r_sync;
   assign io_bus.o_busy = r_busy;

endmodule

// File: tb/tb_phase_gen.sv
// Bench for phase_gen: three instances (PHASES=2,3,4) share one stimulus stream and are
// compared every cycle against a queue-based frame model, plus directed scenario checks.
module tb_phase_gen;

   typedef struct packed {
      logic [7:0] ph;
      logic       start;
      logic       sync;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       step = 1'b0;
   logic [3:0] pw = 4'd0;
   logic [3:0] gap = 4'd1;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   phase_gen_if #(.PHASES(2), .CW(4)) bus0 ();
   phase_gen_if #(.PHASES(3), .CW(4)) bus1 ();
   phase_gen_if #(.PHASES(4), .CW(4)) bus2 ();

   assign bus0.i_en = en;   assign bus0.i_mode = mode; assign bus0.i_step = step;
   assign bus0.i_pw = pw;   assign bus0.i_gap = gap;
   assign bus1.i_en = en;   assign bus1.i_mode = mode; assign bus1.i_step = step;
   assign bus1.i_pw = pw;   assign bus1.i_gap = gap;
   assign bus2.i_en = en;   assign bus2.i_mode = mode; assign bus2.i_step = step;
   assign bus2.i_pw = pw;   assign bus2.i_gap = gap;

   phase_gen #(.PHASES(2), .CW(4)) u_dut0 (.i_clk(clk), .i_rst(rst), .io_bus(bus0.slave));
   phase_gen #(.PHASES(3), .CW(4)) u_dut1 (.i_clk(clk), .i_rst(rst), .io_bus(bus1.slave));
   phase_gen #(.PHASES(4), .CW(4)) u_dut2 (.i_clk(clk), .i_rst(rst), .io_bus(bus2.slave));

   logic [7:0] a_ph [3];
   logic [2:0] a_os;
   logic [2:0] a_sync;
   logic [2:0] a_busy;

   assign a_ph[0] = 8'(bus0.o_ph);
   assign a_ph[1] = 8'(bus1.o_ph);
   assign a_ph[2] = 8'(bus2.o_ph);
   assign a_os    = {bus2.o_s, bus1.o_s, bus0.o_s};
   assign a_sync  = {bus2.o_sync, bus1.o_sync, bus0.o_sync};
   assign a_busy  = {bus2.o_busy, bus1.o_busy, bus0.o_busy};

   // Reference model: each started phase is expanded into its list of per-cycle outputs.
   ent_t       mq [3][$];
   bit         m_run [3];
   int         m_phase [3];
   bit         m_step_r [3];
   bit         m_en_r = 1'b0;
   bit         m_mode_r = 1'b0;
   logic [7:0] e_ph [3];
   logic       e_os [3];
   logic       e_sync [3];
   logic       e_busy [3];

   task automatic chk(input string tag, input int k, input logic [7:0] got,
                      input logic [7:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s inst%0d observed=%h expected=%h t=%0t", tag, k, got, exp, $time);
      end
   endtask

   task automatic expand(input int k, input int p);
      ent_t e;
      m_phase[k] = p;
      for (int i = 0; i <= int'(pw); i++) begin
         e.ph    = 8'(1 << p);
         e.start = (i == 0);
         e.sync  = (i == 0) && (p == 0);
         mq[k].push_back(e);
      end
      for (int i = 0; i < int'(gap); i++) begin
         e = '0;
         mq[k].push_back(e);
      end
   endtask

   task automatic model_edge();
      ent_t e;
      bit   go;
      bit   busy_old;
      for (int k = 0; k < 3; k++) begin
         if (!rst) begin
            mq[k].delete();
            m_run[k]    = 1'b0;
            m_phase[k]  = 0;
            m_step_r[k] = 1'b0;
            e_ph[k]     = 8'd0;
            e_os[k]     = 1'b1;
            e_sync[k]   = 1'b0;
            e_busy[k]   = 1'b0;
         end else begin
            busy_old = e_busy[k];
            go       = m_en_r && (!m_mode_r || m_step_r[k]);
            if (mq[k].size() == 0) begin
               if (!m_run[k]) begin
                  if (go) begin
                     m_run[k] = 1'b1;
                     expand(k, 0);
                  end
               end else if (m_phase[k] < k + 1) begin
                  expand(k, m_phase[k] + 1);
               end else if (!m_mode_r && m_en_r) begin
                  expand(k, 0);
               end else begin
                  m_run[k] = 1'b0;
               end
            end
            if (mq[k].size() != 0) begin
               e         = mq[k].pop_front();
               e_ph[k]   = e.ph;
               e_sync[k] = e.sync;
               e_busy[k] = 1'b1;
               if (e.start) e_os[k] = ~e_os[k];
            end else begin
               e_ph[k]   = 8'd0;
               e_sync[k] = 1'b0;
               e_busy[k] = 1'b0;
            end
            m_step_r[k] = step && !busy_old;
         end
      end
      m_en_r   = rst ? en : 1'b0;
      m_mode_r = rst ? mode : 1'b0;
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk("ph", k, a_ph[k], e_ph[k]);
         chk("o_s", k, {7'd0, a_os[k]}, {7'd0, e_os[k]});
         chk("sync", k, {7'd0, a_sync[k]}, {7'd0, e_sync[k]});
         chk("busy", k, {7'd0, a_busy[k]}, {7'd0, e_busy[k]});
         chk("onehot0", k, {7'd0, $onehot0(a_ph[k])}, 8'd1);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((a_busy != 3'b000 || m_run[0] || m_run[1] || m_run[2]) && n < 200) begin
         tick();
         n++;
      end
      chk("idle_timeout", 0, (n < 200) ? 8'd1 : 8'd0, 8'd1);
   endtask

   task automatic wait_ph(input int k, input int b);
      int n = 0;
      while (!a_ph[k][b] && n < 100) begin
         tick();
         n++;
      end
      chk("ph_timeout", k, (n < 100) ? 8'd1 : 8'd0, 8'd1);
   endtask

   initial begin
      logic [7:0] pat [4];
      int         n;
      pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h02; pat[3] = 8'h00;

      // Reset state
      repeat (2) tick();
      chk("rst_ph", 0, a_ph[0], 8'h00);
      chk("rst_os", 0, {7'd0, a_os[0]}, 8'd1);

      // Legacy two-phase equivalence, EN high from reset release
      en = 1'b1; mode = 1'b0; pw = 4'd0; gap = 4'd1;
      rst = 1'b1;
      tick();
      chk("legacy_lat", 0, a_ph[0], 8'h00);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("legacy_ph", 0, a_ph[0], pat[i % 4]);
         chk("legacy_os", 0, {7'd0, a_os[0]}, ((i >> 1) % 2 == 1) ? 8'd1 : 8'd0);
         chk("legacy_sync", 0, {7'd0, a_sync[0]}, (i % 4 == 0) ? 8'd1 : 8'd0);
      end
      en = 1'b0;
      wait_idle();

      // Wide back-to-back frame
      pw = 4'd2; gap = 4'd0; en = 1'b1;
      repeat (30) tick();
      en = 1'b0;
      wait_idle();

      // Stop mid-frame during PH[1] of the three-phase instance
      pw = 4'd1; gap = 4'd1; en = 1'b1;
      wait_ph(1, 1);
      en = 1'b0;
      repeat (20) tick();
      chk("stop_busy", 1, {7'd0, a_busy[1]}, 8'd0);
      chk("stop_ph", 1, a_ph[1], 8'h00);

      // Step mode: one frame per STEP, STEP while busy ignored
      mode = 1'b1; en = 1'b1; step = 1'b1;
      tick();
      step = 1'b0;
      repeat (3) tick();
      step = 1'b1;
      tick();
      step = 1'b0;
      wait_idle();
      step = 1'b1;
      tick();
      step = 1'b0;
      chk("step_lat_busy", 0, {7'd0, a_busy[0]}, 8'd0);
      tick();
      chk("step_start_busy", 0, {7'd0, a_busy[0]}, 8'd1);
      chk("step_start_ph", 0, a_ph[0], 8'h01);
      wait_idle();

      // Live reprogram of PW during PH[0]
      mode = 1'b0; pw = 4'd0; gap = 4'd1; en = 1'b1;
      wait_ph(0, 0);
      pw = 4'd3;
      wait_ph(0, 1);
      n = 0;
      while (a_ph[0][1] && n < 20) begin
         n++;
         tick();
      end
      chk("reprog_width", 0, 8'(n), 8'd4);

      // Reset mid-phase with PW=5
      pw = 4'd5;
      wait_ph(1, 1);
      rst = 1'b0;
      tick();
      chk("midrst_ph", 1, a_ph[1], 8'h00);
      chk("midrst_os", 1, {7'd0, a_os[1]}, 8'd1);
      chk("midrst_busy", 1, {7'd0, a_busy[1]}, 8'd0);
      rst = 1'b1;
      tick();
      chk("restart_lat", 0, a_ph[0], 8'h00);
      tick();
      chk("restart_ph0", 0, a_ph[0], 8'h01);
      en = 1'b0;
      wait_idle();

      // Randomized run; GAP only changes while every instance is idle
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 9) != 0);
         mode = ($urandom_range(0, 3) == 0);
         step = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) pw = 4'($urandom_range(0, 3));
         if (!m_run[0] && !m_run[1] && !m_run[2] && $urandom_range(0, 1) == 0)
            gap = 4'($urandom_range(0, 2));
         tick();
      end
      en = 1'b0; step = 1'b0;
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
